pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter SIZE, default 8, PC width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (>=1).
REQ-003 SHALL have parameter EDGE_MODE, default 1: 1 = advance on rising edge of incr; 0 = advance every cycle incr is high.
REQ-004 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-005 SHALL have ports: clk  input  1  sole clock, rising edge; all state updates on it.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 incr  input  1  advance request.
REQ-008 load  input  1  absolute jump to target.
REQ-009 branch  input  1  relative jump by offset.
REQ-010 call  input  1  push return address, jump to target.
REQ-011 ret  input  1  pop return address into PC.
REQ-012 target  input  SIZE  absolute address for load/call.
REQ-013 offset  input  SIZE  two's-complement displacement for branch.
REQ-014 out  output  SIZE  current PC, registered.
REQ-015 stack_empty  output  1  stack holds 0 entries.
REQ-016 stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-017 stack_err  output  1  one-cycle pulse on illegal call/ret.

Function
REQ-018 Commands SHALL be sampled each rising clk; out SHALL update on the same edge (1-cycle latency).
REQ-019 Priority SHALL be ret > call > load > branch > incr; only the highest asserted command acts per cycle.
REQ-020 ret with stack non-empty: out <= top entry; depth - 1.
REQ-021 ret with stack empty: out, stack unchanged; stack_err = 1 next cycle.
REQ-022 call with stack non-full: push out+1 (mod 2^SIZE); out <= target; depth + 1.
REQ-023 call with stack full: out, stack unchanged; stack_err = 1 next cycle; lower-priority commands ignored that cycle.
REQ-024 load: out <= target.
REQ-025 branch: out <= out + offset, mod 2^SIZE (sign-extension implicit at equal width).
REQ-026 incr, EDGE_MODE=1: out <= out+1 only when incr=1 and previous-cycle incr sample=0.
REQ-027 incr, EDGE_MODE=0: out <= out+1 every cycle incr=1.
REQ-028 Previous-cycle incr sample SHALL update every cycle regardless of which command wins.
REQ-029 All PC arithmetic SHALL wrap: all-ones + 1 -> 0; no carry output.
REQ-030 No command asserted: out holds.
REQ-031 stack_err SHALL be 0 in every cycle not following an illegal call/ret.
REQ-032 stack_empty/stack_full SHALL be combinational decodes of registered depth.

Reset
REQ-033 reset=1 at rising clk: out <= RESET_ADDR, depth <= 0, stack_err <= 0, incr sample <= 0; all commands ignored.
REQ-034 Stack entry contents need not be cleared; they SHALL be unreachable once depth=0.
REQ-035 After reset, stack_empty=1, stack_full=0; incr held high through reset release SHALL (EDGE_MODE=1) produce exactly one increment on the first non-reset edge.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the command-select enum (CMD_NONE, CMD_INCR, CMD_BRANCH, CMD_LOAD, CMD_CALL, CMD_RET) and priority-decode function.
REQ-037 Sub-module pc_ret_stack SHALL implement the LIFO (push, pop, data, depth, full, empty, synchronous reset); pc_seq instantiates it once.
REQ-038 Depth counter width SHALL be $clog2(STACK_DEPTH+1).

Verification
REQ-039 SIZE=8, reset, incr held 1 for 5 cycles then 0 -> out=1 only (EDGE_MODE=1); EDGE_MODE=0 -> out=5.
REQ-040 out=8'hFF, incr pulse -> out=8'h00; out=8'h05, branch offset=8'hFB -> out=8'h00.
REQ-041 out=8'h10, call target=8'h40 -> out=8'h40, stack_empty=0; ret -> out=8'h11, stack_empty=1.
REQ-042 STACK_DEPTH=4, 5 calls -> stack_full=1 after 4th; 5th yields stack_err pulse, out unchanged.
REQ-043 Empty stack, ret+load+incr same cycle -> stack_err pulse, out unchanged (ret wins, fails).
REQ-044 Mid-sequence reset with depth=2, RESET_ADDR=8'h20 -> next cycle out=8'h20, stack_empty=1, stack_err=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: command select and
// the fixed-priority decode that picks one command per cycle.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_INCR,
      CMD_BRANCH,
      CMD_LOAD,
      CMD_CALL,
      CMD_RET
   } cmd_e;

   // ret > call > load > branch > incr. An illegal call/ret still wins here.
   function automatic cmd_e decode_cmd(
      input logic ret,
      input logic call,
      input logic load,
      input logic branch,
      input logic incr_fire
   );
      if (ret)            return CMD_RET;
      else if (call)      return CMD_CALL;
      else if (load)      return CMD_LOAD;
      else if (branch)    return CMD_BRANCH;
      else if (incr_fire) return CMD_INCR;
      else                return CMD_NONE;
   endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push writes at depth, pop exposes entry depth-1;
// only the depth counter is reset.
module pc_ret_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int DW = $clog2(DEPTH + 1),
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] data,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2**AW];
   logic [WIDTH-1:0] mem_d [2**AW];
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;
   logic [DW-1:0]    depth_dec;

   assign depth_dec = depth_q - DW'(1);
   assign empty     = (depth_q == '0);
   assign full      = (depth_q == DW'(DEPTH));
   assign depth     = depth_q;
   assign data      = mem_q[depth_dec[AW-1:0]];

   // NOTE: every variable gets a default before any branch so no path
   // leaves it unassigned; otherwise a latch is inferred.
   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      if (push && !full) begin
         mem_d[depth_q[AW-1:0]] = push_data;
         depth_d                = depth_q + DW'(1);
      end else if (pop && !empty) begin
         depth_d = depth_dec;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // update together from pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) depth_q <= '0;
      else       depth_q <= depth_d;
   end

   // NOTE: entry storage is deliberately not reset; depth=0 makes every
   // entry unreachable, and leaving it unreset lets it map to plain RAM/flops.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with increment, branch, load, call/ret and a
// return-address stack; one command acts per cycle by fixed priority.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int              SIZE        = 8,
   parameter int              STACK_DEPTH = 4,
   parameter int              EDGE_MODE   = 1,
   parameter logic [SIZE-1:0] RESET_ADDR  = '0,
   localparam int             DW          = $clog2(STACK_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            incr,
   input  logic            load,
   input  logic            branch,
   input  logic            call,
   input  logic            ret,
   input  logic [SIZE-1:0] target,
   input  logic [SIZE-1:0] offset,
   output logic [SIZE-1:0] out,
   output logic            stack_empty,
   output logic            stack_full,
   output logic            stack_err
);

   logic [SIZE-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic            incr_prev_q, incr_prev_d;
   logic            incr_fire;
   logic            push, pop;
   logic            can_push, can_pop;
   logic [SIZE-1:0] ret_addr;
   logic [SIZE-1:0] stk_top;
   logic [DW-1:0]   stk_depth;
   cmd_e            cmd;

   pc_ret_stack #(
      .WIDTH (SIZE),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (ret_addr),
      .data      (stk_top),
      .depth     (stk_depth),
      .full      (stack_full),
      .empty     (stack_empty)
   );

   // Edge mode compares against last cycle's raw incr, whatever command won.
   assign incr_fire   = (EDGE_MODE != 0) ? (incr & ~incr_prev_q) : incr;
   assign incr_prev_d = incr;
   assign ret_addr    = pc_q + SIZE'(1);
   assign can_pop     = (stk_depth != '0);
   assign can_push    = (stk_depth != DW'(STACK_DEPTH));
   assign cmd         = decode_cmd(ret, call, load, branch, incr_fire);

   always_comb begin
      pc_d  = pc_q;
      err_d = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      case (cmd)
         CMD_RET: begin
            if (can_pop) begin
               pc_d = stk_top;
               pop  = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         CMD_CALL: begin
            if (can_push) begin
               pc_d = target;
               push = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         CMD_LOAD:   pc_d = target;
         CMD_BRANCH: pc_d = pc_q + offset;
         CMD_INCR:   pc_d = pc_q + SIZE'(1);
         default:    pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_ADDR;
         err_q       <= 1'b0;
         incr_prev_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         err_q       <= err_d;
         incr_prev_q <= incr_prev_d;
      end
   end

   assign out       = pc_q;
   assign stack_err = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: edge-mode instance a (RESET_ADDR=0) and
// level-mode instance b (RESET_ADDR=8'h20) share every input.
module tb_pc_seq;

   logic       clk = 1'b0;
   logic       reset, incr, load, branch, call, ret;
   logic [7:0] target, offset;
   logic [7:0] a_out, b_out;
   logic       a_empty, a_full, a_err, b_empty, b_full, b_err;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   pc_seq #(.SIZE(8), .STACK_DEPTH(4), .EDGE_MODE(1), .RESET_ADDR(8'h00)) dut_a (
      .clk(clk), .reset(reset), .incr(incr), .load(load), .branch(branch),
      .call(call), .ret(ret), .target(target), .offset(offset),
      .out(a_out), .stack_empty(a_empty), .stack_full(a_full), .stack_err(a_err)
   );

   pc_seq #(.SIZE(8), .STACK_DEPTH(4), .EDGE_MODE(0), .RESET_ADDR(8'h20)) dut_b (
      .clk(clk), .reset(reset), .incr(incr), .load(load), .branch(branch),
      .call(call), .ret(ret), .target(target), .offset(offset),
      .out(b_out), .stack_empty(b_empty), .stack_full(b_full), .stack_err(b_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; incr = 1'b0; load = 1'b0; branch = 1'b0;
      call = 1'b0; ret = 1'b0; target = 8'h00; offset = 8'h00;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (a_out !== 8'h00) begin bad++; $display("FAIL reset_a_out got=%h exp=00", a_out); end
      total++; if (b_out !== 8'h20) begin bad++; $display("FAIL reset_b_out got=%h exp=20", b_out); end
      total++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b exp=1/0", a_empty, a_full); end
      total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", a_err); end
   endtask

   task automatic test_incr_hold();
      idle();
      reset = 1'b1;
      incr  = 1'b1;
      step();
      reset = 1'b0;
      step();
      total++; if (a_out !== 8'h01) begin bad++; $display("FAIL incr_first_edge got=%h exp=01", a_out); end
      repeat (4) step();
      incr = 1'b0;
      step();
      total++; if (a_out !== 8'h01) begin bad++; $display("FAIL incr_edge_mode got=%h exp=01", a_out); end
      total++; if (b_out !== 8'h25) begin bad++; $display("FAIL incr_level_mode got=%h exp=25", b_out); end
   endtask

   task automatic test_wrap();
      idle();
      load = 1'b1; target = 8'hFF;
      step();
      load = 1'b0; incr = 1'b1;
      step();
      total++; if (a_out !== 8'h00) begin bad++; $display("FAIL wrap_incr_a got=%h exp=00", a_out); end
      total++; if (b_out !== 8'h00) begin bad++; $display("FAIL wrap_incr_b got=%h exp=00", b_out); end
      incr = 1'b0;
      step();
   endtask

   task automatic test_branch();
      idle();
      load = 1'b1; target = 8'h05;
      step();
      load = 1'b0; branch = 1'b1; offset = 8'hFB;
      step();
      total++; if (a_out !== 8'h00) begin bad++; $display("FAIL branch_back got=%h exp=00", a_out); end
      offset = 8'h10;
      step();
      total++; if (a_out !== 8'h10) begin bad++; $display("FAIL branch_fwd got=%h exp=10", a_out); end
      offset = 8'h03; incr = 1'b1;
      step();
      total++; if (a_out !== 8'h13) begin bad++; $display("FAIL branch_over_incr got=%h exp=13", a_out); end
      branch = 1'b0;
      step();
      total++; if (a_out !== 8'h13) begin bad++; $display("FAIL incr_sample_tracks got=%h exp=13", a_out); end
      total++; if (b_out !== 8'h14) begin bad++; $display("FAIL incr_level_after_branch got=%h exp=14", b_out); end
      incr = 1'b0;
      step();
   endtask

   task automatic test_call_ret();
      idle();
      load = 1'b1; target = 8'h10;
      step();
      load = 1'b0; call = 1'b1; target = 8'h40;
      step();
      total++; if (a_out !== 8'h40 || a_empty !== 1'b0) begin bad++; $display("FAIL call got out=%h empty=%b exp=40/0", a_out, a_empty); end
      call = 1'b0; ret = 1'b1;
      step();
      total++; if (a_out !== 8'h11 || a_empty !== 1'b1) begin bad++; $display("FAIL ret got out=%h empty=%b exp=11/1", a_out, a_empty); end
      ret = 1'b0;
      step();
   endtask

   task automatic test_stack_full();
      logic [7:0] tgt [4];
      logic [7:0] pops [4];
      tgt  = '{8'h50, 8'h60, 8'h70, 8'h80};
      pops = '{8'h71, 8'h61, 8'h51, 8'h01};
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         call = 1'b1; target = tgt[i];
         step();
         if (i == 2) begin
            total++; if (a_full !== 1'b0) begin bad++; $display("FAIL full_early got=%b exp=0", a_full); end
         end
      end
      total++; if (a_full !== 1'b1 || a_out !== 8'h80) begin bad++; $display("FAIL full_after4 full=%b out=%h exp=1/80", a_full, a_out); end
      target = 8'h90; branch = 1'b1; offset = 8'h01;
      step();
      total++; if (a_err !== 1'b1 || a_out !== 8'h80) begin bad++; $display("FAIL overflow err=%b out=%h exp=1/80", a_err, a_out); end
      call = 1'b0; branch = 1'b0;
      step();
      total++; if (a_err !== 1'b0 || a_out !== 8'h80) begin bad++; $display("FAIL err_one_cycle err=%b out=%h exp=0/80", a_err, a_out); end
      ret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (a_out !== pops[i]) begin bad++; $display("FAIL pop%0d got=%h exp=%h", i, a_out, pops[i]); end
      end
      total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL empty_after_pops got=%b exp=1", a_empty); end
      ret = 1'b0;
   endtask

   task automatic test_ret_empty();
      idle();
      ret = 1'b1; load = 1'b1; target = 8'h33; incr = 1'b1;
      step();
      total++; if (a_err !== 1'b1 || a_out !== 8'h01) begin bad++; $display("FAIL underflow err=%b out=%h exp=1/01", a_err, a_out); end
      idle();
      step();
      total++; if (a_err !== 1'b0 || a_out !== 8'h01) begin bad++; $display("FAIL underflow_clear err=%b out=%h exp=0/01", a_err, a_out); end
   endtask

   task automatic test_midreset();
      idle();
      call = 1'b1; target = 8'h40;
      step();
      target = 8'h48;
      step();
      total++; if (a_empty !== 1'b0 || a_out !== 8'h48) begin bad++; $display("FAIL depth2 empty=%b out=%h exp=0/48", a_empty, a_out); end
      reset = 1'b1; target = 8'h99;
      step();
      idle();
      total++; if (a_out !== 8'h00 || b_out !== 8'h20) begin bad++; $display("FAIL midreset_out a=%h b=%h exp=00/20", a_out, b_out); end
      total++; if (a_empty !== 1'b1 || b_empty !== 1'b1 || a_err !== 1'b0 || b_err !== 1'b0) begin
         bad++; $display("FAIL midreset_flags empty=%b%b err=%b%b exp=11/00", a_empty, b_empty, a_err, b_err);
      end
      ret = 1'b1;
      step();
      total++; if (a_err !== 1'b1 || a_out !== 8'h00) begin bad++; $display("FAIL ret_after_reset err=%b out=%h exp=1/00", a_err, a_out); end
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_incr_hold();
      test_wrap();
      test_branch();
      test_call_ret();
      test_stack_full();
      test_ret_empty();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
